// File: rtl/alu_cmd_master_if.sv
// Command and UART FIFO signal bundle for alu_cmd_master.
// The master modport is the controller view; slave is the environment view.
interface alu_cmd_master_if #(
  parameter int unsigned DBIT = 8
);
  logic            start;
  logic [DBIT-1:0] op_a;
  logic [DBIT-1:0] op_b;
  logic [5:0]      op_code;
  logic            busy;
  logic            done;
  logic [DBIT-1:0] result;
  logic            timeout_err;
  logic            tx_full;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;

  modport master (
    input  start, op_a, op_b, op_code, tx_full, rx_empty, r_data,
    output busy, done, result, timeout_err, wr_uart, w_data, rd_uart
  );

  modport slave (
    output start, op_a, op_b, op_code, tx_full, rx_empty, r_data,
    input  busy, done, result, timeout_err, wr_uart, w_data, rd_uart
  );
endinterface

// File: rtl/alu_cmd_master.sv
// Sends operand A, operand B and opcode over a UART FIFO pair, then waits for one result byte.
// Optional response timeout is built only when ALU_CMD_MASTER_TIMEOUT_EN is defined.
module alu_cmd_master #(
  parameter int unsigned DBIT        = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               reset,
  alu_cmd_master_if.master   bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StSendA,
    StSendB,
    StSendOp,
    StWaitRx,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [DBIT-1:0] a_q, a_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [5:0]      op_q, op_d;
  logic [DBIT-1:0] result_q, result_d;
  logic            wr;
  logic            rd;
  logic [DBIT-1:0] wdata;
  logic            to_hit;

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  assign to_hit = (state_q == StWaitRx) && (cnt_q == CntW'(TIMEOUT_CYC));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    wr       = 1'b0;
    rd       = 1'b0;
    wdata    = '0;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          op_d    = bus.op_code;
          state_d = bus.rx_empty ? StSendA : StFlush;
        end else begin
          // Discard stale bytes so they cannot be taken as the next response.
          rd = !bus.rx_empty;
        end
      end
      StFlush: begin
        if (bus.rx_empty) state_d = StSendA;
        else              rd      = 1'b1;
      end
      StSendA: begin
        wdata = a_q;
        wr    = !bus.tx_full;
        if (wr) state_d = StSendB;
      end
      StSendB: begin
        wdata = b_q;
        wr    = !bus.tx_full;
        if (wr) state_d = StSendOp;
      end
      StSendOp: begin
        wdata = DBIT'(op_q);
        wr    = !bus.tx_full;
        if (wr) begin
          state_d = StWaitRx;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWaitRx: begin
        if (to_hit) begin
          state_d = StIdle;
        end else if (!bus.rx_empty) begin
          rd       = 1'b1;
          result_d = bus.r_data;
          state_d  = StDone;
        end else begin
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.result      = result_q;
  assign bus.timeout_err = to_hit;
  assign bus.wr_uart     = wr;
  assign bus.w_data      = wdata;
  // The idle drain is combinational on rx_empty, so mask it while reset is held.
  assign bus.rd_uart     = rd & reset;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Scoreboard bench for alu_cmd_master: a UART/far-end ALU model, a stimulus process
// and an independent monitor that pops expected writes and results from queues.
module tb_alu_cmd_master;
  localparam int unsigned DBIT   = 8;
  localparam int unsigned TO_CYC = 16;

  typedef struct {
    bit         is_to;
    logic [7:0] res;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_cmd_master_if #(.DBIT(DBIT)) bus ();

  alu_cmd_master #(
    .DBIT        (DBIT),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         ev_seen = 0;
  logic [7:0] exp_wr[$];
  ev_t        exp_ev[$];
  logic [7:0] rxq[$];
  logic [7:0] stage[$];
  int         exp_lat    = 0;
  int         exp_flush  = -1;
  bit         respond_en = 1'b1;
  int         resp_delay = 0;
  bit         bp_after_a = 1'b0;
  bit         rand_bp    = 1'b0;
  logic [7:0] model_res  = '0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Far-end ALU behaviour.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return (a << 1) ^ b ^ {2'b00, op};
    endcase
  endfunction

  function automatic void rx_update();
    bus.rx_empty = (rxq.size() == 0);
    bus.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // UART FIFO pair plus the remote ALU that answers after three bytes.
  initial begin
    bit         s_rd, s_wr;
    logic [7:0] s_wd;
    logic [7:0] pend_val;
    int         pend_n  = -1;
    int         bp_left = 0;
    forever begin
      @(negedge clk);
      s_rd = bus.rd_uart;
      s_wr = bus.wr_uart;
      s_wd = bus.w_data;
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
        stage.delete();
        pend_n      = -1;
        bp_left     = 0;
        bus.tx_full = 1'b0;
      end else begin
        if (s_rd && rxq.size() != 0) void'(rxq.pop_front());
        if (s_wr) begin
          stage.push_back(s_wd);
          if (stage.size() == 1 && bp_after_a) begin
            bp_left    = 4;
            bp_after_a = 1'b0;
          end
          if (stage.size() == 3) begin
            if (respond_en) begin
              pend_val = alu_ref(stage[0], stage[1], stage[2][5:0]);
              pend_n   = resp_delay;
            end
            stage.delete();
          end
        end
        if (pend_n == 0) begin
          rxq.push_back(pend_val);
          pend_n = -1;
        end else if (pend_n > 0) begin
          pend_n--;
        end
        if (bp_left > 0) begin
          bus.tx_full = 1'b1;
          bp_left--;
        end else begin
          bus.tx_full = rand_bp ? ($urandom_range(3) == 0) : 1'b0;
        end
      end
      rx_update();
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write, done or timeout.
  initial begin
    int  acc_cyc = 0, rd_since = 0, wr_in_txn = 0, last_op_cyc = 0;
    bit  got_wr = 1'b0, prev_rd = 1'b0, idle_next = 1'b0;
    ev_t e;
    logic [7:0] w;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (idle_next) begin
          chk(bus.busy == 1'b0, "idle_after_timeout", bus.busy, 0);
          idle_next = 1'b0;
        end
        if (bus.start && !bus.busy) begin
          acc_cyc   = cyc;
          rd_since  = 0;
          wr_in_txn = 0;
          got_wr    = 1'b0;
        end else if (bus.busy && !got_wr && bus.rd_uart) begin
          rd_since++;
        end
        if (bus.wr_uart) begin
          if (!got_wr) begin
            got_wr = 1'b1;
            if (exp_flush >= 0) chk(rd_since == exp_flush, "flush_pops", rd_since, exp_flush);
          end
          wr_in_txn++;
          if (wr_in_txn == 3) last_op_cyc = cyc;
          if (exp_lat > 0) chk(cyc == acc_cyc + wr_in_txn, "wr_cycle", cyc - acc_cyc, wr_in_txn);
          if (exp_wr.size() == 0) begin
            chk(1'b0, "unexpected_write", bus.w_data, 0);
          end else begin
            w = exp_wr.pop_front();
            chk(bus.w_data == w, "wr_data", bus.w_data, w);
          end
        end
        if (bus.done) begin
          chk(prev_rd, "done_after_rd", prev_rd, 1);
          chk(bus.busy, "busy_in_done", bus.busy, 1);
          if (exp_lat > 0) chk(cyc == acc_cyc + exp_lat, "done_latency", cyc - acc_cyc, exp_lat);
          if (exp_ev.size() == 0) begin
            chk(1'b0, "unexpected_done", bus.result, 0);
          end else begin
            e = exp_ev.pop_front();
            chk(!e.is_to, "done_vs_timeout", 1, 0);
            chk(bus.result == e.res, "result", bus.result, e.res);
          end
          ev_seen++;
        end
        if (bus.timeout_err) begin
          chk(!bus.done, "timeout_with_done", bus.done, 0);
          chk(cyc == last_op_cyc + 1 + TO_CYC, "timeout_cycle", cyc - last_op_cyc - 1, TO_CYC);
          if (exp_ev.size() == 0) begin
            chk(1'b0, "unexpected_timeout", 1, 0);
          end else begin
            e = exp_ev.pop_front();
            chk(e.is_to, "timeout_vs_done", 0, 1);
            chk(bus.result == e.res, "result_kept", bus.result, e.res);
          end
          idle_next = 1'b1;
          ev_seen++;
        end
      end
      prev_rd = bus.rd_uart;
    end
  end

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input int delay, input bit respond, input int lat, input int stale,
                         input bit ign);
    int target;
    exp_wr.push_back(a);
    exp_wr.push_back(b);
    exp_wr.push_back({2'b00, op});
    if (respond) begin
      model_res = alu_ref(a, b, op);
      exp_ev.push_back('{is_to: 1'b0, res: model_res});
    end else begin
      exp_ev.push_back('{is_to: 1'b1, res: model_res});
    end
    resp_delay = delay;
    respond_en = respond;
    exp_lat    = lat;
    exp_flush  = stale;
    for (int i = 0; i < stale; i++) rxq.push_back(8'hA0 + 8'(i) * 8'h11);
    rx_update();
    target      = ev_seen + 1;
    bus.op_a    = a;
    bus.op_b    = b;
    bus.op_code = op;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.op_a    = 8'($urandom);
    bus.op_b    = 8'($urandom);
    bus.op_code = 6'($urandom);
    if (ign) begin
      repeat (3) step();
      bus.op_a  = 8'hFF;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    for (int i = 0; i < 300 && ev_seen < target; i++) step();
    chk(ev_seen >= target, "txn_complete", ev_seen, target);
    step();
    step();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.op_a    = '0;
    bus.op_b    = '0;
    bus.op_code = '0;
    bus.tx_full = 1'b0;
    rxq.push_back(8'hC3);
    rx_update();
    #1 reset = 1'b0;
    repeat (3) step();
    chk({bus.busy, bus.done, bus.timeout_err, bus.wr_uart, bus.rd_uart} == 5'b0,
        "reset_ctrl", {bus.busy, bus.done, bus.timeout_err, bus.wr_uart, bus.rd_uart}, 0);
    chk(bus.w_data == 8'h00, "reset_wdata", bus.w_data, 0);
    chk(bus.result == 8'h00, "reset_result", bus.result, 0);
    reset = 1'b1;
    repeat (3) step();
    chk(rxq.size() == 0, "idle_drain", rxq.size(), 0);

    // basic, backpressure, stale data, ignored start
    run_txn(8'h05, 8'h03, 6'h20, 0, 1'b1, 5, 0, 1'b0);
    bp_after_a = 1'b1;
    run_txn(8'h05, 8'h03, 6'h20, 0, 1'b1, 0, 0, 1'b0);
    run_txn(8'h05, 8'h03, 6'h20, 1, 1'b1, 0, 2, 1'b0);
    run_txn(8'h12, 8'h34, 6'h22, 8, 1'b1, 0, 0, 1'b1);

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    run_txn(8'h40, 8'h02, 6'h24, 0, 1'b0, 0, 0, 1'b0);
    rxq.push_back(8'h77);
    rx_update();
    repeat (3) step();
    chk(rxq.size() == 0, "late_drain", rxq.size(), 0);
`endif

    // Reset in SEND_B
    exp_wr.push_back(8'h33);
    exp_wr.push_back(8'h44);
    exp_wr.push_back(8'h20);
    bus.op_a    = 8'h33;
    bus.op_b    = 8'h44;
    bus.op_code = 6'h20;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk({bus.busy, bus.done, bus.timeout_err, bus.wr_uart, bus.rd_uart} == 5'b0,
        "midreset_ctrl", {bus.busy, bus.done, bus.timeout_err, bus.wr_uart, bus.rd_uart}, 0);
    chk(bus.w_data == 8'h00, "midreset_wdata", bus.w_data, 0);
    chk(bus.result == 8'h00, "midreset_result", bus.result, 0);
    step();
    step();
    exp_wr.delete();
    exp_ev.delete();
    model_res = 8'h00;
    reset = 1'b1;
    step();
    run_txn(8'h0A, 8'h01, 6'h22, 0, 1'b1, 5, 0, 1'b0);

    rand_bp = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [5:0] op;
      int         st;
      op = ($urandom_range(1) == 0) ? 6'(6'h20 + 6'($urandom_range(6))) : 6'($urandom);
      st = ($urandom_range(3) == 0) ? $urandom_range(2, 1) : 0;
      run_txn(8'($urandom), 8'($urandom), op, $urandom_range(4), 1'b1, 0, st, 1'b0);
    end
    rand_bp = 1'b0;
    repeat (3) step();

    chk(exp_wr.size() == 0, "wr_queue_empty", exp_wr.size(), 0);
    chk(exp_ev.size() == 0, "ev_queue_empty", exp_ev.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001 Parameter DBIT, default 8: byte width of operands, result and UART FIFO data.
REQ-002 Parameter TIMEOUT_CYC, default 100000: response timeout in clk cycles; used only with ALU_CMD_MASTER_TIMEOUT_EN.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one ALU transaction; sampled only in IDLE.
REQ-006 op_a  input  DBIT  operand A; captured when start is accepted.
REQ-007 op_b  input  DBIT  operand B; captured when start is accepted.
REQ-008 op_code  input  6  ALU operation code; captured when start is accepted.
REQ-009 busy  output  1  high while a transaction is in progress.
REQ-010 done  output  1  one-cycle pulse; result is valid.
REQ-011 result  output  DBIT  last received ALU result.
REQ-012 timeout_err  output  1  one-cycle pulse; response not received in time.
REQ-013 tx_full  input  1  UART TX FIFO full.
REQ-014 wr_uart  output  1  UART TX FIFO write strobe.
REQ-015 w_data  output  DBIT  UART TX FIFO write data.
REQ-016 rx_empty  input  1  UART RX FIFO empty.
REQ-017 r_data  input  DBIT  UART RX FIFO head word, first-word-fall-through.
REQ-018 rd_uart  output  1  UART RX FIFO pop strobe.

Function
REQ-019 Function: FSM states IDLE, FLUSH, SEND_A, SEND_B, SEND_OP, WAIT_RX, DONE.
REQ-020 Start acceptance: IDLE with start=1 captures op_a, op_b and op_code; goes to FLUSH if rx_empty=0, else SEND_A; start in any other state is ignored.
REQ-021 Idle drain: IDLE with start=0 and rx_empty=0 asserts rd_uart to discard stale bytes.
REQ-022 FLUSH asserts rd_uart each cycle while rx_empty=0; goes to SEND_A on the first cycle rx_empty=1.
REQ-023 Write handshake: in SEND_A, SEND_B and SEND_OP, wr_uart = !tx_full (combinational); w_data = captured A, B and {2'b00, op_code} respectively.
REQ-024 Each SEND state advances only on a cycle with wr_uart=1; exactly one write per byte; the state and w_data are held while tx_full=1.
REQ-025 Read handshake: WAIT_RX with rx_empty=0 asserts rd_uart for one cycle and registers r_data into result on that edge, then enters DONE.
REQ-026 DONE pulses done for one cycle and returns to IDLE; result holds until the next successful transaction.
REQ-027 busy=1 in every state except IDLE.
REQ-028 Latency: with tx_full=0, rx_empty=1 at start and the response already present, writes occur on cycles 1-3 after acceptance, rd_uart on cycle 4, done on cycle 5.
REQ-029 rd_uart and wr_uart are never high outside the states listed above.

Reset
REQ-030 reset=0 asynchronously forces IDLE, clears the captured operands and timeout counter, sets result=0, and holds busy, done, timeout_err, wr_uart, rd_uart and w_data at 0.
REQ-031 Reset asserted mid-transaction abandons it; no done pulse follows; bytes already written are not recalled.

Configuration
REQ-032 Macro ALU_CMD_MASTER_TIMEOUT_EN defined: a counter clears on WAIT_RX entry and increments each WAIT_RX cycle with rx_empty=1.
REQ-033 When that counter reaches TIMEOUT_CYC: timeout_err pulses for one cycle, result is unchanged, no done pulse occurs, and the FSM returns to IDLE.
REQ-034 A late response byte after a timeout is discarded by the idle drain or FLUSH.
REQ-035 Macro not defined: WAIT_RX waits indefinitely, no counter logic is built, and timeout_err is tied to 0.

Verification
REQ-036 Scenario basic: A=8'h05, B=8'h03, op=6'h20, tx_full=0, model returns 8'h08 -> writes 05,03,20 on consecutive cycles; done with result=8'h08 on cycle 5.
REQ-037 Scenario backpressure: tx_full=1 for 4 cycles during SEND_B -> B written exactly once after release; byte order 05,03,20 preserved; done one cycle after the rd_uart cycle.
REQ-038 Scenario stale data: 2 bytes in RX FIFO when start=1 -> two rd_uart pops in FLUSH before the first write; the result comes from the fresh response only.
REQ-039 Scenario ignored start: start pulsed during WAIT_RX with A=8'hFF -> no extra writes; the transaction completes with the original operands.
REQ-040 Scenario timeout (macro defined, TIMEOUT_CYC=16): no response -> timeout_err pulse 16 cycles after WAIT_RX entry; result keeps its previous value; busy=0 on the next cycle.
REQ-041 Scenario reset: reset=0 while in SEND_B -> all outputs 0 immediately; after release, start with A=8'h0A, B=8'h01, op=6'h22 completes normally.
